// File: rtl/arm_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package : cu_pkg
// Purpose : Shared definitions for the ARM-subset microprogrammed control
//           unit. Holds the microstate enum, control-word bit positions,
//           ALU opcodes, datapath select encodings and condition codes.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package cu_pkg;

  localparam int ST_W = 8;

  typedef enum logic [ST_W-1:0] {
    S_RESET  = 8'd0,
    S_FETCH1 = 8'd1,
    S_FETCH2 = 8'd2,
    S_FETCH3 = 8'd3,
    S_DECODE = 8'd4,
    S_DP     = 8'd5,
    S_MEM_I  = 8'd6,
    S_MEM_R  = 8'd7,
    S_LD1    = 8'd8,
    S_LD2    = 8'd9,
    S_ST1    = 8'd10,
    S_ST2    = 8'd11,
    S_BR     = 8'd12,
    S_BL     = 8'd13,
    S_BR2    = 8'd14
  } state_t;

  // Control word single-bit fields
  localparam int CW_MFA     = 31;
  localparam int CW_RW_RAM  = 30;
  localparam int CW_SALU    = 29;
  localparam int CW_RF_RW   = 28;
  localparam int CW_SSAB    = 27;  // MDR input: 1 = register B bus, 0 = RAM
  localparam int CW_SSOP    = 26;
  localparam int CW_SMA     = 25;  // MAR input: 1 = register A bus, 0 = ALU
  localparam int CW_STA     = 24;  // shifter source: 1 = immediate, 0 = Rm
  localparam int CW_MAR_EN  = 23;
  localparam int CW_SR_EN   = 22;
  localparam int CW_MDR_EN  = 21;
  localparam int CW_IR_EN   = 20;
  localparam int CW_SHT_EN  = 19;
  localparam int CW_ISE_EN  = 18;
  localparam int CW_SGN_EN  = 17;
  localparam int CW_CLR     = 16;

  // Control word multi-bit fields (LSB positions)
  localparam int CW_DSS_LO   = 14;
  localparam int CW_WRA_LO   = 12;
  localparam int CW_SRA_LO   = 10;
  localparam int CW_SRB_LO   = 8;
  localparam int CW_SISE_LO  = 6;
  localparam int CW_SALUB_LO = 4;
  localparam int CW_ALUA_LO  = 0;

  // ALU opcodes follow the ARM data-processing opcode field
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_RSB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ADC = 4'b0101;
  localparam logic [3:0] ALU_SBC = 4'b0110;
  localparam logic [3:0] ALU_RSC = 4'b0111;
  localparam logic [3:0] ALU_TST = 4'b1000;
  localparam logic [3:0] ALU_TEQ = 4'b1001;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_CMN = 4'b1011;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_BIC = 4'b1110;
  localparam logic [3:0] ALU_MVN = 4'b1111;

  // Register-file write address select
  localparam logic [1:0] WRA_RD = 2'b00;
  localparam logic [1:0] WRA_PC = 2'b01;
  localparam logic [1:0] WRA_LR = 2'b10;
  localparam logic [1:0] WRA_RN = 2'b11;
  // Register-file read port A select
  localparam logic [1:0] SRA_RN = 2'b00;
  localparam logic [1:0] SRA_PC = 2'b01;
  localparam logic [1:0] SRA_RD = 2'b10;
  localparam logic [1:0] SRA_RM = 2'b11;
  // Register-file read port B select
  localparam logic [1:0] SRB_RM = 2'b00;
  localparam logic [1:0] SRB_RD = 2'b01;
  localparam logic [1:0] SRB_RS = 2'b10;
  localparam logic [1:0] SRB_PC = 2'b11;
  // Register-file write data select
  localparam logic [1:0] DSS_ALU = 2'b00;
  localparam logic [1:0] DSS_MDR = 2'b01;
  localparam logic [1:0] DSS_PC  = 2'b10;
  // ALU B operand select
  localparam logic [1:0] SALUB_SHIFT  = 2'b00;
  localparam logic [1:0] SALUB_CONST4 = 2'b01;
  localparam logic [1:0] SALUB_IMM    = 2'b10;
  localparam logic [1:0] SALUB_ZERO   = 2'b11;
  // Immediate sign/zero extender source select
  localparam logic [1:0] SISE_IMM12 = 2'b00;
  localparam logic [1:0] SISE_IMM8R = 2'b01;
  localparam logic [1:0] SISE_IMM24 = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/arm_control_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module  : cu_cond_eval
// Purpose : Combinational ARM condition-code evaluator.
// Ports   : cond  [3:0] in  - instruction condition field IR[31:28]
//           flags [3:0] in  - {N,Z,C,V}
//           pass        out - 1 when the instruction should execute
// Rev     : 1.0  initial release
// ============================================================================
module cu_cond_eval
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // 1111: never
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/arm_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : arm_control_unit
// Purpose : Microprogrammed controller for the ARM-subset CPU. A Moore FSM
//           whose state indexes a microcode ROM; a few IR fields patch the
//           ROM word in the execute states.
// Ports   : CLK        in   clock, rising edge
//           Reset      in   synchronous active-high reset
//           CW  [31:0] out  control word to data_path
//           IR  [31:0] in   instruction register
//           MFC        in   memory function complete
//           Flags [3:0] in  {N,Z,C,V}
// Rev     : 1.0  initial release
// ============================================================================
module arm_control_unit
  import cu_pkg::*;
#(
  parameter int STATE_W = 8,
  parameter int CW_W    = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  output logic [CW_W-1:0] CW,
  input  logic [31:0]     IR,
  input  logic            MFC,
  input  logic [3:0]      Flags
);

  state_t          state;
  state_t          state_next;
  logic [CW_W-1:0] cw_word;
  logic            cond_pass;
  logic            unused_ir;

  assign unused_ir = ^IR[19:0];

  cu_cond_eval u_cond_eval (
    .cond  (IR[31:28]),
    .flags (Flags),
    .pass  (cond_pass)
  );

  // Microcode ROM: unlisted indices read as an all-zero word.
  function automatic logic [CW_W-1:0] rom_word(input logic [STATE_W-1:0] idx);
    logic [CW_W-1:0] w;
    w = '0;
    case (idx)
      S_RESET: w[CW_CLR] = 1'b1;
      S_FETCH1: begin
        w[CW_MAR_EN]            = 1'b1;
        w[CW_SMA]               = 1'b1;
        w[CW_SRA_LO +: 2]       = SRA_PC;
      end
      S_FETCH2, S_LD1: begin
        w[CW_MFA]               = 1'b1;
        w[CW_RW_RAM]            = RW_READ;
        w[CW_MDR_EN]            = 1'b1;
      end
      S_FETCH3: begin
        w[CW_IR_EN]             = 1'b1;
        w[CW_RF_RW]             = 1'b1;
        w[CW_WRA_LO +: 2]       = WRA_PC;
        w[CW_SRA_LO +: 2]       = SRA_PC;
        w[CW_SALUB_LO +: 2]     = SALUB_CONST4;
        w[CW_ALUA_LO +: 4]      = ALU_ADD;
      end
      S_DP: begin
        // ALUA, RF_RW, SR_EN and STA are patched from IR below.
        w[CW_SHT_EN]            = 1'b1;
        w[CW_WRA_LO +: 2]       = WRA_RD;
        w[CW_SRA_LO +: 2]       = SRA_RN;
        w[CW_SRB_LO +: 2]       = SRB_RM;
        w[CW_SISE_LO +: 2]      = SISE_IMM8R;
        w[CW_SALUB_LO +: 2]     = SALUB_SHIFT;
        w[CW_DSS_LO +: 2]       = DSS_ALU;
      end
      S_MEM_I: begin
        w[CW_MAR_EN]            = 1'b1;
        w[CW_ISE_EN]            = 1'b1;
        w[CW_SRA_LO +: 2]       = SRA_RN;
        w[CW_SISE_LO +: 2]      = SISE_IMM12;
        w[CW_SALUB_LO +: 2]     = SALUB_IMM;
      end
      S_MEM_R: begin
        w[CW_MAR_EN]            = 1'b1;
        w[CW_SHT_EN]            = 1'b1;
        w[CW_SRA_LO +: 2]       = SRA_RN;
        w[CW_SRB_LO +: 2]       = SRB_RM;
        w[CW_SALUB_LO +: 2]     = SALUB_SHIFT;
      end
      S_LD2: begin
        w[CW_RF_RW]             = 1'b1;
        w[CW_WRA_LO +: 2]       = WRA_RD;
        w[CW_DSS_LO +: 2]       = DSS_MDR;
      end
      S_ST1: begin
        w[CW_MDR_EN]            = 1'b1;
        w[CW_SSAB]              = 1'b1;
        w[CW_SRB_LO +: 2]       = SRB_RD;
      end
      S_ST2: begin
        w[CW_MFA]               = 1'b1;
        w[CW_RW_RAM]            = RW_WRITE;
      end
      S_BL: begin
        // LR <= PC + 0
        w[CW_RF_RW]             = 1'b1;
        w[CW_WRA_LO +: 2]       = WRA_LR;
        w[CW_SRA_LO +: 2]       = SRA_PC;
        w[CW_SALUB_LO +: 2]     = SALUB_ZERO;
        w[CW_ALUA_LO +: 4]      = ALU_ADD;
      end
      S_BR2: begin
        w[CW_RF_RW]             = 1'b1;
        w[CW_SGN_EN]            = 1'b1;
        w[CW_ISE_EN]            = 1'b1;
        w[CW_WRA_LO +: 2]       = WRA_PC;
        w[CW_SRA_LO +: 2]       = SRA_PC;
        w[CW_SISE_LO +: 2]      = SISE_IMM24;
        w[CW_SALUB_LO +: 2]     = SALUB_IMM;
        w[CW_ALUA_LO +: 4]      = ALU_ADD;
      end
      default: w = '0;  // S_DECODE, S_BR and illegal indices
    endcase
    return w;
  endfunction

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH1;
    cw_word    = rom_word(state);

    case (state)
      S_RESET:  state_next = S_FETCH1;
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: state_next = MFC ? S_FETCH3 : S_FETCH2;
      S_FETCH3: state_next = S_DECODE;
      S_DECODE: begin
        if (cond_pass) begin
          case (IR[27:25])
            3'b000, 3'b001: state_next = S_DP;
            3'b010:         state_next = S_MEM_I;
            3'b011:         state_next = S_MEM_R;
            3'b101:         state_next = S_BR;
            default:        state_next = S_FETCH1;  // unsupported class: NOP
          endcase
        end
      end
      S_DP: begin
        cw_word[CW_STA]            = IR[25];
        cw_word[CW_ALUA_LO +: 4]   = IR[24:21];
        // TST/TEQ/CMP/CMN (opcode 10xx) only update flags
        cw_word[CW_RF_RW]          = ~(IR[24] & ~IR[23]);
        cw_word[CW_SR_EN]          = IR[20];
        state_next                 = S_FETCH1;
      end
      S_MEM_I, S_MEM_R: begin
        // U bit picks offset direction; B bit ignored, always word access
        cw_word[CW_ALUA_LO +: 4]   = IR[23] ? ALU_ADD : ALU_SUB;
        state_next                 = IR[20] ? S_LD1 : S_ST1;
      end
      S_LD1:    state_next = MFC ? S_LD2 : S_LD1;
      S_LD2:    state_next = S_FETCH1;
      S_ST1:    state_next = S_ST2;
      S_ST2:    state_next = MFC ? S_FETCH1 : S_ST2;
      S_BR:     state_next = IR[24] ? S_BL : S_BR2;
      S_BL:     state_next = S_BR2;
      S_BR2:    state_next = S_FETCH1;
      default:  state_next = S_FETCH1;
    endcase
  end

  assign CW = cw_word;

endmodule
`default_nettype wire

// File: tb/tb_arm_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_arm_control_unit
// Purpose : Self-checking bench for arm_control_unit: directed vector table,
//           hand-written reset/wait sequences and random instruction streams
//           checked against an instruction-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_arm_control_unit;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cw;
  logic [31:0] ir;
  logic        mfc;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arm_control_unit #(.STATE_W(8), .CW_W(32)) dut (
    .CLK   (clk),
    .Reset (reset),
    .CW    (cw),
    .IR    (ir),
    .MFC   (mfc),
    .Flags (flags)
  );

  function automatic logic [31:0] b(input int pos);
    return 32'h1 << pos;
  endfunction

  function automatic logic [31:0] fld(input int lo, input logic [3:0] v);
    return {28'd0, v} << lo;
  endfunction

  localparam logic [31:0] BM = (32'h1 << CW_MFA) | (32'h1 << CW_RF_RW) |
                               (32'h1 << CW_MAR_EN) | (32'h1 << CW_SR_EN) |
                               (32'h1 << CW_MDR_EN) | (32'h1 << CW_IR_EN) |
                               (32'h1 << CW_SGN_EN) | (32'h1 << CW_CLR);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_t target, input int limit);
    int k;
    k = 0;
    while (dut.state !== target && k < limit) begin
      tick();
      k++;
    end
    n_checks++;
    if (dut.state !== target) begin
      n_fail++;
      $display("FAIL wait_state: got %0d expected %0d", dut.state, target);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef struct {
    state_t      st;
    logic [31:0] val;
    logic [31:0] mask;
    logic        waitc;
    logic        mfc;
  } step_t;

  step_t steps[$];

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input state_t st, input logic [31:0] val, input logic [31:0] xm,
                      input logic w, input logic m);
    steps.push_back('{st: st, val: val, mask: BM | xm, waitc: w, mfc: m});
  endtask

  // A memory wait state: d cycles with MFC low, then one with MFC high.
  task automatic push_wait(input state_t st, input logic [31:0] val, input logic [31:0] xm,
                           input int d);
    for (int k = 0; k < d; k++) push(st, val, xm, 1'b1, 1'b0);
    push(st, val, xm, 1'b1, 1'b1);
  endtask

  task automatic build(input logic [31:0] i, input logic [3:0] f, input int d);
    logic [31:0] rd_cw;
    steps.delete();
    rd_cw = b(CW_MFA) | b(CW_RW_RAM) | b(CW_MDR_EN);
    push(S_FETCH1, b(CW_MAR_EN) | fld(CW_SRA_LO, {2'b00, SRA_PC}), fld(CW_SRA_LO, 4'h3), 0, 0);
    push_wait(S_FETCH2, rd_cw, b(CW_RW_RAM), d);
    push(S_FETCH3, b(CW_IR_EN) | b(CW_RF_RW) | fld(CW_WRA_LO, {2'b00, WRA_PC}) |
                   fld(CW_SALUB_LO, {2'b00, SALUB_CONST4}) | fld(CW_ALUA_LO, 4'b0100),
         fld(CW_WRA_LO, 4'h3) | fld(CW_SALUB_LO, 4'h3) | fld(CW_ALUA_LO, 4'hF), 0, 0);
    push(S_DECODE, 32'h0, 32'h0, 0, 0);
    if (cond_ok(i[31:28], f)) begin
      case (i[27:25])
        3'b000, 3'b001: begin
          push(S_DP, b(CW_SHT_EN) | (i[25] ? b(CW_STA) : 32'h0) | fld(CW_ALUA_LO, i[24:21]) |
                     ((i[24:23] != 2'b10) ? b(CW_RF_RW) : 32'h0) | (i[20] ? b(CW_SR_EN) : 32'h0),
               b(CW_SHT_EN) | b(CW_STA) | fld(CW_ALUA_LO, 4'hF), 0, 0);
        end
        3'b010, 3'b011: begin
          push((i[25] ? S_MEM_R : S_MEM_I),
               b(CW_MAR_EN) | fld(CW_ALUA_LO, i[23] ? 4'b0100 : 4'b0010),
               fld(CW_ALUA_LO, 4'hF), 0, 0);
          if (i[20]) begin
            push_wait(S_LD1, rd_cw, b(CW_RW_RAM), d);
            push(S_LD2, b(CW_RF_RW) | fld(CW_DSS_LO, {2'b00, DSS_MDR}), fld(CW_DSS_LO, 4'h3), 0, 0);
          end else begin
            push(S_ST1, b(CW_MDR_EN), 32'h0, 0, 0);
            push_wait(S_ST2, b(CW_MFA), b(CW_RW_RAM), d);
          end
        end
        3'b101: begin
          push(S_BR, 32'h0, 32'h0, 0, 0);
          if (i[24])
            push(S_BL, b(CW_RF_RW) | fld(CW_WRA_LO, {2'b00, WRA_LR}), fld(CW_WRA_LO, 4'h3), 0, 0);
          push(S_BR2, b(CW_RF_RW) | b(CW_SGN_EN) | b(CW_ISE_EN) | fld(CW_WRA_LO, {2'b00, WRA_PC}),
               b(CW_ISE_EN) | fld(CW_WRA_LO, 4'h3), 0, 0);
        end
        default: ;
      endcase
    end
  endtask

  // Drive one instruction through the DUT (starting in S_FETCH1), checking
  // every cycle; flags and MFC are randomised wherever they must not matter.
  task automatic run_instr(input logic [31:0] i, input logic [3:0] f, input int d);
    build(i, f, d);
    ir = i;
    foreach (steps[k]) begin
      check($sformatf("state ir=%h step=%0d", i, k), 32'(dut.state), 32'(steps[k].st));
      check($sformatf("cw ir=%h step=%0d", i, k), cw & steps[k].mask, steps[k].val);
      flags = (steps[k].st == S_DECODE) ? f : 4'($urandom);
      mfc   = steps[k].waitc ? steps[k].mfc : 1'($urandom);
      tick();
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] ir;
    logic [3:0]  flags;
    int          len;       // cycles spent after S_DECODE before S_FETCH1
    logic        rf;        // RF_RW in first cycle after S_DECODE
    logic        sr;        // SR_EN in first cycle after S_DECODE
    logic [3:0]  alua;
    logic        chk_alua;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    int          n;
    logic [31:0] r;

    tbl.push_back('{ir:32'h03A0_1005, flags:4'h0, len:0, rf:0, sr:0, alua:4'h0, chk_alua:0});
    tbl.push_back('{ir:32'h03A0_1005, flags:4'h4, len:1, rf:1, sr:0, alua:4'hD, chk_alua:1});
    tbl.push_back('{ir:32'hE150_0002, flags:4'h0, len:1, rf:0, sr:1, alua:4'hA, chk_alua:1});
    tbl.push_back('{ir:32'hE081_0002, flags:4'h0, len:1, rf:1, sr:0, alua:4'h4, chk_alua:1});
    tbl.push_back('{ir:32'hE110_0001, flags:4'h0, len:1, rf:0, sr:1, alua:4'h8, chk_alua:1});
    tbl.push_back('{ir:32'hE591_0004, flags:4'h0, len:3, rf:0, sr:0, alua:4'h4, chk_alua:1});
    tbl.push_back('{ir:32'hE511_0004, flags:4'h0, len:3, rf:0, sr:0, alua:4'h2, chk_alua:1});
    tbl.push_back('{ir:32'hE581_0004, flags:4'h0, len:3, rf:0, sr:0, alua:4'h4, chk_alua:1});
    tbl.push_back('{ir:32'hE791_0002, flags:4'h0, len:3, rf:0, sr:0, alua:4'h4, chk_alua:1});
    tbl.push_back('{ir:32'hEAFF_FFFE, flags:4'h0, len:2, rf:0, sr:0, alua:4'h0, chk_alua:0});
    tbl.push_back('{ir:32'hEBFF_FFFE, flags:4'h0, len:3, rf:0, sr:0, alua:4'h0, chk_alua:0});
    tbl.push_back('{ir:32'hF3A0_1005, flags:4'hF, len:0, rf:0, sr:0, alua:4'h0, chk_alua:0});
    tbl.push_back('{ir:32'hE890_0000, flags:4'h0, len:0, rf:0, sr:0, alua:4'h0, chk_alua:0});
    tbl.push_back('{ir:32'hEF00_0000, flags:4'h0, len:0, rf:0, sr:0, alua:4'h0, chk_alua:0});
    tbl.push_back('{ir:32'hC3A0_1005, flags:4'h8, len:0, rf:0, sr:0, alua:4'h0, chk_alua:0});
    tbl.push_back('{ir:32'hC3A0_1005, flags:4'h0, len:1, rf:1, sr:0, alua:4'hD, chk_alua:1});
    tbl.push_back('{ir:32'h83A0_1005, flags:4'h2, len:1, rf:1, sr:0, alua:4'hD, chk_alua:1});
    tbl.push_back('{ir:32'h83A0_1005, flags:4'h6, len:0, rf:0, sr:0, alua:4'h0, chk_alua:0});

    // ---- reset held two cycles ----
    reset = 1'b1; ir = 32'h0; mfc = 1'b0; flags = 4'h0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("reset state", 32'(dut.state), 32'd0);
      check("reset cw", cw & BM, b(CW_CLR));
    end
    reset = 1'b0;
    tick();
    check("post-reset state", 32'(dut.state), 32'(S_FETCH1));
    check("post-reset MAR_EN", 32'(cw[CW_MAR_EN]), 32'd1);

    // ---- fetch with MFC held low three cycles, then cond-failing MOVEQ ----
    run_instr(32'h03A0_1005, 4'h0, 3);
    // ---- BL with slow memory on the fetch ----
    run_instr(32'hEBFF_FFFE, 4'h0, 2);

    // ---- directed table ----
    mfc = 1'b1;
    foreach (tbl[t]) begin
      ir    = tbl[t].ir;
      flags = tbl[t].flags;
      wait_state(S_DECODE, 20);
      tick();
      cap = cw;
      n = 0;
      while (dut.state !== S_FETCH1 && n < 10) begin
        n++;
        tick();
      end
      check($sformatf("tbl%0d len", t), 32'(n), 32'(tbl[t].len));
      check($sformatf("tbl%0d RF_RW", t), 32'(cap[CW_RF_RW]), 32'(tbl[t].rf));
      check($sformatf("tbl%0d SR_EN", t), 32'(cap[CW_SR_EN]), 32'(tbl[t].sr));
      if (tbl[t].chk_alua)
        check($sformatf("tbl%0d ALUA", t), 32'(cap[3:0]), 32'(tbl[t].alua));
    end

    // ---- random instruction stream ----
    for (int k = 0; k < 250; k++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[31:28] = 4'hE;
      run_instr(r, 4'($urandom), $urandom_range(0, 3));
    end

    // ---- reset while LDR waits on memory ----
    ir = 32'hE591_0004; flags = 4'h0; mfc = 1'b1;
    wait_state(S_MEM_I, 20);
    mfc = 1'b0;
    tick();
    check("ld1 state", 32'(dut.state), 32'(S_LD1));
    check("ld1 MFA", 32'(cw[CW_MFA]), 32'd1);
    tick();
    check("ld1 hold state", 32'(dut.state), 32'(S_LD1));
    reset = 1'b1;
    tick();
    check("abort state", 32'(dut.state), 32'd0);
    check("abort cw", cw & BM, b(CW_CLR));
    reset = 1'b0; mfc = 1'b1;
    tick();
    check("abort recover", 32'(dut.state), 32'(S_FETCH1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
